// File: rtl/axi_lite_bram_ctrl.sv
// ---------------------------------------------------------------------------
// axi_lite_bram_ctrl
//
// Purpose:
//   AXI4-Lite slave that maps its address space onto a single-port,
//   word-addressed block RAM with a one-cycle registered read. Only one
//   transaction is in flight at a time. A write is accepted only when its
//   address and data arrive together. A complete write pair has priority
//   over a read request that arrives in the same cycle.
//
// Optional feature:
//   AXIL_BRAM_RANGE_CHK_EN - when defined, a request whose byte address has
//   any bit set above the BRAM window is answered with SLVERR (2'b10). Such
//   a write never enables the BRAM, and such a read returns zero. Response
//   timing does not change. When undefined, the upper address bits are
//   ignored, so the BRAM aliases through the whole space, and every response
//   is OKAY.
//
// Ports:
//   clk, rst                  clock (rising edge), async active-high reset
//   s_aw*/s_w*/s_b*           AXI-Lite write address / data / response
//   s_ar*/s_r*                AXI-Lite read address / data
//   bram_we, bram_addr,       BRAM byte write enables, word address,
//   bram_din, bram_dout       write data, registered read data
// ---------------------------------------------------------------------------
module axi_lite_bram_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int BRAM_ADDR_W = 10,
  parameter int DATA_W      = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_W-1:0]      s_awaddr,
  input  logic                   s_awvalid,
  output logic                   s_awready,
  input  logic [DATA_W-1:0]      s_wdata,
  input  logic [DATA_W/8-1:0]    s_wstrb,
  input  logic                   s_wvalid,
  output logic                   s_wready,
  output logic [1:0]             s_bresp,
  output logic                   s_bvalid,
  input  logic                   s_bready,
  input  logic [ADDR_W-1:0]      s_araddr,
  input  logic                   s_arvalid,
  output logic                   s_arready,
  output logic [DATA_W-1:0]      s_rdata,
  output logic [1:0]             s_rresp,
  output logic                   s_rvalid,
  input  logic                   s_rready,
  output logic [DATA_W/8-1:0]    bram_we,
  output logic [BRAM_ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0]      bram_din,
  input  logic [DATA_W-1:0]      bram_dout
);

  localparam int STRB_W = DATA_W / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WR_EXEC,
    WR_RESP,
    RD_EXEC,
    RD_CAP,
    RD_RESP
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [STRB_W-1:0] r_wstrb;
  logic [DATA_W-1:0] r_rdata;
  logic [1:0]        r_bresp;
  logic [1:0]        r_rresp;

  logic w_wr_go;
  logic w_rd_go;
  logic w_oor;

  // The two byte-offset bits never select anything: the BRAM is word-wide.
  logic w_unused_addr_lsb;
  assign w_unused_addr_lsb = ^r_addr[1:0];

`ifdef AXIL_BRAM_RANGE_CHK_EN
  // Any address bit set above the BRAM window marks the request out of range.
  assign w_oor = |r_addr[ADDR_W-1:BRAM_ADDR_W+2];
`else
  // Upper bits are ignored, so the BRAM aliases through the address space.
  assign w_oor = 1'b0;
  logic w_unused_addr_msb;
  assign w_unused_addr_msb = ^r_addr[ADDR_W-1:BRAM_ADDR_W+2];
`endif

  // The same latched address serves both reads and writes. Only one
  // transaction is ever in flight.
  assign bram_addr = r_addr[BRAM_ADDR_W+1:2];
  assign bram_din  = r_wdata;

  // The valids decode straight from the state register. Reset therefore
  // drops them in the same instant that it forces IDLE.
  assign s_bvalid = (r_state == WR_RESP);
  assign s_rvalid = (r_state == RD_RESP);
  assign s_bresp  = r_bresp;
  assign s_rresp  = r_rresp;
  assign s_rdata  = r_rdata;

  always_comb begin
    w_state_next = r_state;
    s_awready    = 1'b0;
    s_wready     = 1'b0;
    s_arready    = 1'b0;
    bram_we      = '0;
    w_wr_go      = 1'b0;
    w_rd_go      = 1'b0;

    case (r_state)
      IDLE: begin
        // AW and W are accepted together or not at all. A complete write
        // pair beats a simultaneous read request.
        if (s_awvalid && s_wvalid) begin
          s_awready    = 1'b1;
          s_wready     = 1'b1;
          w_wr_go      = 1'b1;
          w_state_next = WR_EXEC;
        end else if (s_arvalid) begin
          s_arready    = 1'b1;
          w_rd_go      = 1'b1;
          w_state_next = RD_EXEC;
        end
      end
      WR_EXEC: begin
        if (!w_oor) begin
          bram_we = r_wstrb;
        end
        w_state_next = WR_RESP;
      end
      WR_RESP: begin
        if (s_bready) begin
          w_state_next = IDLE;
        end
      end
      RD_EXEC: begin
        // The address is presented in this state. The BRAM registers it on
        // the closing edge, so its data is valid during RD_CAP.
        w_state_next = RD_CAP;
      end
      RD_CAP: begin
        w_state_next = RD_RESP;
      end
      RD_RESP: begin
        if (s_rready) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_rdata <= '0;
      r_bresp <= RESP_OKAY;
      r_rresp <= RESP_OKAY;
    end else begin
      r_state <= w_state_next;

      if (w_wr_go) begin
        r_addr  <= s_awaddr;
        r_wdata <= s_wdata;
        r_wstrb <= s_wstrb;
      end else if (w_rd_go) begin
        r_addr <= s_araddr;
      end

      // The response code is set once, on the way into WR_RESP. It then
      // holds for as long as the master stalls B.
      if (r_state == WR_EXEC) begin
        r_bresp <= w_oor ? RESP_SLVERR : RESP_OKAY;
      end

      // Read data and code are captured once. They hold through any R stall.
      if (r_state == RD_CAP) begin
        r_rdata <= w_oor ? '0 : bram_dout;
        r_rresp <= w_oor ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_bram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_bram_ctrl
//
// Self-checking bench for axi_lite_bram_ctrl. A behavioural BRAM with a
// one-cycle registered read sits behind the DUT. The bench has two parts:
// hand-written sequences for exact-cycle timing, back-pressure, priority and
// reset corners, and a table of write/read vectors with precomputed
// expected results. The expected values follow the build: they differ when
// AXIL_BRAM_RANGE_CHK_EN is defined.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axi_lite_bram_ctrl;

  localparam int ADDR_W      = 32;
  localparam int BRAM_ADDR_W = 10;
  localparam int DATA_W      = 32;

`ifdef AXIL_BRAM_RANGE_CHK_EN
  localparam logic [1:0] OOR_RESP = 2'b10;
  localparam bit         RCHK     = 1'b1;
`else
  localparam logic [1:0] OOR_RESP = 2'b00;
  localparam bit         RCHK     = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [ADDR_W-1:0]      s_awaddr = '0;
  logic                   s_awvalid = 1'b0;
  logic                   s_awready;
  logic [DATA_W-1:0]      s_wdata = '0;
  logic [3:0]             s_wstrb = '0;
  logic                   s_wvalid = 1'b0;
  logic                   s_wready;
  logic [1:0]             s_bresp;
  logic                   s_bvalid;
  logic                   s_bready = 1'b0;
  logic [ADDR_W-1:0]      s_araddr = '0;
  logic                   s_arvalid = 1'b0;
  logic                   s_arready;
  logic [DATA_W-1:0]      s_rdata;
  logic [1:0]             s_rresp;
  logic                   s_rvalid;
  logic                   s_rready = 1'b0;
  logic [3:0]             bram_we;
  logic [BRAM_ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0]      bram_din;
  logic [DATA_W-1:0]      bram_dout = '0;

  axi_lite_bram_ctrl #(
    .ADDR_W(ADDR_W), .BRAM_ADDR_W(BRAM_ADDR_W), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din), .bram_dout(bram_dout)
  );

  always #5 clk = ~clk;

  // Behavioural BRAM: byte-write, read-first, one-cycle registered read.
  logic [31:0] mem [0:1023] = '{default: 32'h0};
  int we_cnt = 0;
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (bram_we[b]) mem[bram_addr][b*8 +: 8] <= bram_din[b*8 +: 8];
    end
    bram_dout <= mem[bram_addr];
    if (bram_we != 4'b0000) we_cnt <= we_cnt + 1;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting, expected handshake within 20 cycles", name);
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    int n;
    @(negedge clk);
    s_awaddr = addr; s_wdata = data; s_wstrb = strb;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    #1;
    n = 0;
    while (!(s_awready && s_wready) && n < 20) begin @(negedge clk); #1; n++; end
    if (n >= 20) timeout("aw/w accept");
    @(negedge clk);
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_bready = 1'b1;
    n = 0;
    while (!s_bvalid && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) timeout("bvalid");
    resp = s_bresp;
    @(negedge clk);
    s_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    int n;
    @(negedge clk);
    s_araddr = addr; s_arvalid = 1'b1;
    #1;
    n = 0;
    while (!s_arready && n < 20) begin @(negedge clk); #1; n++; end
    if (n >= 20) timeout("ar accept");
    @(negedge clk);
    s_arvalid = 1'b0; s_rready = 1'b1;
    n = 0;
    while (!s_rvalid && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) timeout("rvalid");
    data = s_rdata;
    resp = s_rresp;
    @(negedge clk);
    s_rready = 1'b0;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs [13];

  initial begin
    logic [1:0]  resp;
    logic [31:0] rdat;
    int          we0;

    // Vectors continue from the state left by the first sequence
    // (word 4 = DEADBEEF).
    vecs[0]  = '{1'b1, 32'h010, 32'h0000AB00, 4'h2, 32'h0,        2'b00};
    vecs[1]  = '{1'b0, 32'h010, 32'h0,        4'h0, 32'hDEADABEF, 2'b00};
    vecs[2]  = '{1'b1, 32'h004, 32'h12345678, 4'hF, 32'h0,        2'b00};
    vecs[3]  = '{1'b1, 32'h008, 32'hA5A5A5A5, 4'h5, 32'h0,        2'b00};
    vecs[4]  = '{1'b0, 32'h008, 32'h0,        4'h0, 32'h00A500A5, 2'b00};
    vecs[5]  = '{1'b0, 32'h004, 32'h0,        4'h0, 32'h12345678, 2'b00};
    vecs[6]  = '{1'b1, 32'h007, 32'hFFFFFFFF, 4'h8, 32'h0,        2'b00};
    vecs[7]  = '{1'b0, 32'h004, 32'h0,        4'h0, 32'hFF345678, 2'b00};
    vecs[8]  = '{1'b1, 32'hFFC, 32'hCAFEF00D, 4'hF, 32'h0,        2'b00};
    vecs[9]  = '{1'b0, 32'hFFE, 32'h0,        4'h0, 32'hCAFEF00D, 2'b00};
    vecs[10] = '{1'b1, 32'h1000, 32'h55AA55AA, 4'hF, 32'h0,       OOR_RESP};
    vecs[11] = '{1'b0, 32'h000, 32'h0,        4'h0, RCHK ? 32'h0 : 32'h55AA55AA, 2'b00};
    vecs[12] = '{1'b0, 32'h1000, 32'h0,       4'h0, RCHK ? 32'h0 : 32'h55AA55AA, OOR_RESP};

    // ---- reset state ----
    repeat (3) @(negedge clk);
    chk("rst awready", s_awready, 0);
    chk("rst arready", s_arready, 0);
    chk("rst bvalid",  s_bvalid,  0);
    chk("rst rvalid",  s_rvalid,  0);
    chk("rst bram_we", bram_we,   0);
    chk("rst rdata",   s_rdata,   0);

    // ---- release, then a write accepted in the very next cycle ----
    @(negedge clk);
    rst = 1'b0;
    s_awaddr = 32'h010; s_wdata = 32'hDEADBEEF; s_wstrb = 4'hF;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    #1;
    chk("T0 awready", s_awready, 1);
    chk("T0 wready",  s_wready,  1);
    chk("T0 arready", s_arready, 0);
    chk("T0 bram_we", bram_we,   0);
    @(negedge clk);
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    s_araddr = 32'h010; s_arvalid = 1'b1;   // read waits behind the write
    #1;
    chk("T1 bram_we",   bram_we,   4'hF);
    chk("T1 bram_addr", bram_addr, 10'd4);
    chk("T1 bram_din",  bram_din,  32'hDEADBEEF);
    chk("T1 bvalid",    s_bvalid,  0);
    chk("T1 arready",   s_arready, 0);
    @(negedge clk);
    chk("T2 bvalid",  s_bvalid, 1);
    chk("T2 bresp",   s_bresp,  0);
    chk("T2 bram_we", bram_we,  0);
    we0 = we_cnt;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bstall%0d bvalid", i),  s_bvalid,  1);
      chk($sformatf("bstall%0d bresp", i),   s_bresp,   0);
      chk($sformatf("bstall%0d arready", i), s_arready, 0);
      chk($sformatf("bstall%0d bram_we", i), bram_we,   0);
    end
    s_bready = 1'b1;
    #1;
    chk("B hs arready", s_arready, 0);
    @(negedge clk);
    s_bready = 1'b0;
    #1;
    chk("B stall no BRAM write", we_cnt, we0);
    chk("R T0 arready", s_arready, 1);
    @(negedge clk);
    s_arvalid = 1'b0;
    #1;
    chk("R T1 bram_addr", bram_addr, 10'd4);
    chk("R T1 bram_we",   bram_we,   0);
    chk("R T1 rvalid",    s_rvalid,  0);
    @(negedge clk);
    chk("R T2 rvalid", s_rvalid, 0);
    @(negedge clk);
    chk("R T3 rvalid", s_rvalid, 1);
    chk("R T3 rdata",  s_rdata,  32'hDEADBEEF);
    chk("R T3 rresp",  s_rresp,  0);
    s_awaddr = 32'h040; s_wdata = 32'h0; s_wstrb = 4'hF;
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
    we0 = we_cnt;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("rstall%0d rvalid", i),  s_rvalid,  1);
      chk($sformatf("rstall%0d rdata", i),   s_rdata,   32'hDEADBEEF);
      chk($sformatf("rstall%0d awready", i), s_awready, 0);
      chk($sformatf("rstall%0d arready", i), s_arready, 0);
    end
    chk("R stall no BRAM write", we_cnt, we0);
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0; s_rready = 1'b1;
    @(negedge clk);
    s_rready = 1'b0;

    // ---- table-driven vectors ----
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp);
        chk($sformatf("vec%0d wr %h bresp", i, vecs[i].addr), resp, vecs[i].exp_resp);
      end else begin
        axi_read(vecs[i].addr, rdat, resp);
        chk($sformatf("vec%0d rd %h rdata", i, vecs[i].addr), rdat, vecs[i].exp_data);
        chk($sformatf("vec%0d rd %h rresp", i, vecs[i].addr), resp, vecs[i].exp_resp);
      end
    end

    // ---- AW, W and AR all valid in the same cycle ----
    @(negedge clk);
    s_awaddr = 32'h020; s_wdata = 32'h11223344; s_wstrb = 4'hF;
    s_araddr = 32'h020;
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
    #1;
    chk("prio awready", s_awready, 1);
    chk("prio arready", s_arready, 0);
    @(negedge clk);
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    #1;
    chk("prio T1 arready", s_arready, 0);
    @(negedge clk);
    chk("prio T2 bvalid",  s_bvalid,  1);
    chk("prio T2 arready", s_arready, 0);
    s_bready = 1'b1;
    @(negedge clk);
    s_bready = 1'b0;
    #1;
    chk("prio after B arready", s_arready, 1);
    @(negedge clk);
    s_arvalid = 1'b0; s_rready = 1'b1;
    repeat (2) @(negedge clk);
    chk("prio rvalid", s_rvalid, 1);
    chk("prio rdata",  s_rdata,  32'h11223344);
    @(negedge clk);
    s_rready = 1'b0;

    // ---- reset pulsed during WR_EXEC ----
    @(negedge clk);
    s_awaddr = 32'h030; s_wdata = 32'h99999999; s_wstrb = 4'hF;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    #1;
    chk("rstmid awready", s_awready, 1);
    @(negedge clk);
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_bready = 1'b1;
    #1;
    chk("rstmid T1 bram_we", bram_we, 4'hF);
    we0 = we_cnt;
    rst = 1'b1;
    #1;
    chk("rstmid we drops", bram_we,  0);
    chk("rstmid bvalid",   s_bvalid, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstmid no BRAM write", we_cnt, we0);
    chk("rstmid rdata cleared", s_rdata, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("rstmid%0d bvalid", i), s_bvalid, 0);
    end
    s_bready = 1'b0;
    axi_read(32'h030, rdat, resp);
    chk("rstmid word untouched", rdat, 32'h0);
    axi_write(32'h030, 32'h77777777, 4'hF, resp);
    chk("post-rst write bresp", resp, 2'b00);
    axi_read(32'h030, rdat, resp);
    chk("post-rst readback", rdat, 32'h77777777);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish by 200us");
    $fatal(1, "watchdog");
  end

endmodule
